// File: rtl/iter_multiplier_pkg.sv
// Shared types for the iterative RV64M multiplier: operation encoding,
// FSM states and the raw-opcode decoder.
package iter_multiplier_pkg;

  localparam int MUL_OP_W = 3;

  typedef enum logic [MUL_OP_W-1:0] {
    MUL_OP_MUL    = 3'd0,
    MUL_OP_MULH   = 3'd1,
    MUL_OP_MULHSU = 3'd2,
    MUL_OP_MULHU  = 3'd3,
    MUL_OP_MULW   = 3'd4
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Reserved encodings 101-111 execute as a plain MUL.
  function automatic mul_op_t decode_op(input logic [MUL_OP_W-1:0] raw);
    mul_op_t op;
    if (raw > 3'd4) op = MUL_OP_MUL;
    else op = mul_op_t'(raw);
    return op;
  endfunction

endpackage

// File: rtl/iter_multiplier_step.sv
// One radix-2^BITS_PER_CYCLE shift-add step: add chunk*|a| into the upper
// half of the unsigned accumulator, then shift the whole thing right.
module mul_radix_step #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [2*XLEN-1:0]         acc,
  input  logic [XLEN-1:0]           a_abs,
  input  logic [BITS_PER_CYCLE-1:0] chunk,
  output logic [2*XLEN-1:0]         acc_next
);

  localparam int BPC = BITS_PER_CYCLE;

  logic [XLEN+BPC-1:0]     partial;
  logic [XLEN+BPC-1:0]     hi_sum;
  logic [2*XLEN+BPC-1:0]   wide;

  always_comb begin
    partial = '0;
    for (int i = 0; i < BPC; i++) begin
      if (chunk[i]) partial = partial + ({{BPC{1'b0}}, a_abs} << i);
    end
    // The upper half plus chunk*|a| always fits in XLEN+BPC bits, so no carry is lost.
    hi_sum   = {{BPC{1'b0}}, acc[2*XLEN-1:XLEN]} + partial;
    wide     = {hi_sum, acc[XLEN-1:0]};
    acc_next = wide[2*XLEN+BPC-1:BPC];
  end

endmodule

// File: rtl/iter_multiplier.sv
// Multi-cycle RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW) with valid/ready
// handshakes, tag pass-through and flush.
module iter_multiplier
  import iter_multiplier_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 2,
  parameter int TAG_W          = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     op_a,
  input  logic [XLEN-1:0]     op_b,
  input  logic [MUL_OP_W-1:0] mul_op,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  // Handshakes: a request transfers on a rising edge where in_valid && in_ready
  // && !flush; a result transfers where out_valid && out_ready. flush overrides both.

  localparam int BPC    = BITS_PER_CYCLE;
  localparam int N_FULL = XLEN / BPC;
  localparam int N_WORD = 32 / BPC;
  localparam int CNT_W  = $clog2(N_FULL + 1);

  mul_state_t            state, state_next;
  mul_op_t               op_in, op_q;
  logic [XLEN-1:0]       a_abs_q, b_rem_q;
  logic [2*XLEN-1:0]     acc_q, acc_step;
  logic                  neg_q;
  logic [TAG_W-1:0]      tag_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [XLEN-1:0]       result_q;
  logic [TAG_W-1:0]      out_tag_q;

  logic [XLEN-1:0]       a_ext, b_ext, a_abs_in, b_abs_in;
  logic                  a_signed, b_signed, a_neg, b_neg;
  logic [CNT_W-1:0]      cnt_init;
  logic                  accept, step_en, last_step;
  logic [2*XLEN-1:0]     prod_mag, prod_signed;
  logic [XLEN-1:0]       result_sel;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = (i < 32) ? v[i] : v[31];
    return r;
  endfunction

  // Operand conditioning at accept: sign-extend for MULW, then magnitudes.
  always_comb begin
    op_in    = decode_op(mul_op);
    a_ext    = (op_in == MUL_OP_MULW) ? sext32(op_a) : op_a;
    b_ext    = (op_in == MUL_OP_MULW) ? sext32(op_b) : op_b;
    a_signed = (op_in != MUL_OP_MULHU);
    b_signed = (op_in != MUL_OP_MULHU) && (op_in != MUL_OP_MULHSU);
    a_neg    = a_signed && a_ext[XLEN-1];
    b_neg    = b_signed && b_ext[XLEN-1];
    a_abs_in = a_neg ? ('0 - a_ext) : a_ext;
    b_abs_in = b_neg ? ('0 - b_ext) : b_ext;
    cnt_init = (op_in == MUL_OP_MULW) ? CNT_W'(N_WORD) : CNT_W'(N_FULL);
  end

  mul_radix_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BPC)
  ) u_step (
    .acc      (acc_q),
    .a_abs    (a_abs_q),
    .chunk    (b_rem_q[BPC-1:0]),
    .acc_next (acc_step)
  );

  // MULW stops after 32 bits, so its product sits XLEN-32 bits higher.
  always_comb begin
    prod_mag    = (op_q == MUL_OP_MULW) ? (acc_step >> (XLEN - 32)) : acc_step;
    prod_signed = neg_q ? ('0 - prod_mag) : prod_mag;
    case (op_q)
      MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: result_sel = prod_signed[2*XLEN-1:XLEN];
      MUL_OP_MULW: result_sel = sext32(prod_signed[XLEN-1:0]);
      default:     result_sel = prod_signed[XLEN-1:0];
    endcase
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step_en    = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            last_step  = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (flush || out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= MUL_OP_MUL;
      a_abs_q   <= '0;
      b_rem_q   <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      tag_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      out_tag_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q    <= op_in;
        a_abs_q <= a_abs_in;
        b_rem_q <= b_abs_in;
        acc_q   <= '0;
        neg_q   <= a_neg ^ b_neg;
        tag_q   <= in_tag;
        cnt_q   <= cnt_init;
      end
      if (step_en) begin
        acc_q   <= acc_step;
        b_rem_q <= b_rem_q >> BPC;
        cnt_q   <= cnt_q - CNT_W'(1);
      end
      if (last_step) begin
        result_q  <= result_sel;
        out_tag_q <= tag_q;
      end
    end
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = result_q;
  assign out_tag    = out_tag_q;

endmodule
